// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and default constants for the sync_fifo write arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BURST)
//   DATA_WIDTH, ADDR_WIDTH, NUM_REQ, MAX_BURST : default configuration
//   CNT_W       : burst counter width (covers MAX_BURST up to 15)
package sync_fifo_arb_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REQ    = 4;
  localparam int MAX_BURST  = 4;
  localparam int CNT_W      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// Round-robin picker: first asserted req bit at or after rr_ptr, wrapping.
//   req    : request vector
//   rr_ptr : search start index
//   found  : some request is asserted
//   index  : selected requester (0 when nothing found)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Burst round-robin arbiter feeding the write port of sync_fifo.
//   clk, rst      : clock, synchronous active-high reset
//   req, req_data : per-requester write request and flattened data
//   gnt           : one-hot grant (combinational); word consumed at the edge
//   fifo_counter  : FIFO occupancy
//   fifo_wr_en, fifo_data_in : registered FIFO write port
//   owner, busy   : current burst owner, high while in BURST
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = sync_fifo_arb_pkg::NUM_REQ,
  parameter int DATA_WIDTH = sync_fifo_arb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sync_fifo_arb_pkg::ADDR_WIDTH,
  parameter int MAX_BURST  = sync_fifo_arb_pkg::MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [ADDR_WIDTH:0]           fifo_counter,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IW    = $clog2(NUM_REQ);
  localparam int SW    = ADDR_WIDTH + 2;

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic                   fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_WIDTH-1:0]  fifo_data_in_q, fifo_data_in_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;
  logic [SW-1:0]  occ;
  logic           space;
  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic           grant_vld;
  logic [IW-1:0]  grant_idx;

  assign req_words = req_data;

  // A write still sitting in the output register has not reached the
  // counter yet, so it is counted here to avoid overfilling.
  assign occ   = SW'(fifo_counter) + SW'(fifo_wr_en_q);
  assign space = occ < SW'(DEPTH);

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    grant_vld   = 1'b0;
    grant_idx   = owner_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (space && pick_found) begin
            grant_vld   = 1'b1;
            grant_idx   = pick_idx;
            owner_d     = pick_idx;
            burst_cnt_d = CNT_W'(1);
            if (MAX_BURST == 1) rr_ptr_d = inc_wrap(pick_idx);
            else                state_d  = BURST;
          end
        end
        BURST: begin
          // Owner released or burst exhausted: one bubble, pass the pointer on.
          if (!req[owner_q] || burst_cnt_q >= CNT_W'(MAX_BURST)) begin
            rr_ptr_d = inc_wrap(owner_q);
            state_d  = IDLE;
          end else if (space) begin
            grant_vld   = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = grant_vld && (grant_idx == IW'(i));
  end

  assign fifo_wr_en_d   = grant_vld;
  assign fifo_data_in_d = grant_vld ? req_words[grant_idx] : fifo_data_in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      burst_cnt_q    <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      burst_cnt_q    <= burst_cnt_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_data_in_q <= fifo_data_in_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_in_q;
  assign owner        = owner_q;
  assign busy         = (state_q == BURST) && !rst;
endmodule
